// File: rtl/pipe_pkg.sv
// Shared types for pipeline stage registers: occupancy state and its width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int unsigned OCC_W = 2;

  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_t s);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (s)
      EMPTY:   occ = 2'd0;
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = '0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// synchronous flush and a saturating backpressure (stall) cycle counter.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SKID  = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_t      state_q;
  pipe_state_t      state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_xfer;
  logic             out_xfer;
  logic             load_in;
  logic             load_skid;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_of(state_q);

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign load_in   = in_xfer & ((state_q == EMPTY) | out_xfer);
  assign load_skid = (state_q == FULL) & out_xfer;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_xfer) state_d = BUSY;
        BUSY: begin
          // Without a skid slot in_xfer implies out_xfer, so FULL is unreachable.
          if (in_xfer && !out_xfer)      state_d = (SKID != 0) ? FULL : BUSY;
          else if (!in_xfer && out_xfer) state_d = EMPTY;
        end
        FULL:    if (out_xfer) state_d = BUSY;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      if (flush)          main_q <= '0;
      else if (load_in)   main_q <= in_data;
      else if (load_skid) main_q <= skid_q;
    end
  end

  generate
    if (SKID != 0) begin : gen_skid
      logic ready_q;

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          skid_q  <= '0;
          ready_q <= 1'b1;
        end else begin
          if (flush) begin
            skid_q <= '0;
          end else if ((state_q == BUSY) && in_xfer && !out_xfer) begin
            skid_q <= in_data;
          end
          // Registered so upstream never sees a combinational path from out_ready.
          ready_q <= (state_d != FULL);
        end
      end

      assign in_ready = ready_q;
    end else begin : gen_noskid
      assign skid_q   = '0;
      assign in_ready = out_ready | ~out_valid;
    end
  endgenerate

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (out_valid & ~out_ready & ~flush),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Drives a SKID=1 (CNT_W=3) and a SKID=0 (CNT_W=16) stage with identical inputs
// and compares both against queue-based reference models.
module tb_pipe_skid_reg;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        flush;
  logic        cnt_clr;

  logic        rdy1, ov1, rdy0, ov0;
  logic [31:0] od1, od0;
  logic [1:0]  occ1, occ0;
  logic [2:0]  sc1;
  logic [15:0] sc0;

  always #5 CLK = ~CLK;

  pipe_skid_reg #(.WIDTH(32), .SKID(1), .CNT_W(3)) dut1 (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .flush(flush),
    .cnt_clr(cnt_clr), .occupancy(occ1), .stall_cnt(sc1)
  );

  pipe_skid_reg #(.WIDTH(32), .SKID(0), .CNT_W(16)) dut0 (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .flush(flush),
    .cnt_clr(cnt_clr), .occupancy(occ0), .stall_cnt(sc0)
  );

  // Reference state: queue of held entries, last head value, ready and stall count.
  logic [31:0] q1[$];
  logic [31:0] q0[$];
  logic [31:0] last1, last0;
  logic        ready1m;
  int unsigned cnt1, cnt0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q0.delete();
    last1   = '0;
    last0   = '0;
    ready1m = 1'b1;
    cnt1    = 0;
    cnt0    = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid_s1", 32'(ov1), 32'(q1.size() != 0));
    chk("out_data_s1",  od1, last1);
    chk("occupancy_s1", 32'(occ1), 32'(q1.size()));
    chk("stall_cnt_s1", 32'(sc1), cnt1);
    chk("out_valid_s0", 32'(ov0), 32'(q0.size() != 0));
    chk("out_data_s0",  od0, last0);
    chk("occupancy_s0", 32'(occ0), 32'(q0.size()));
    chk("stall_cnt_s0", 32'(sc0), cnt0);
  endtask

  // One clock cycle: drive, check in_ready, clock, update model, check outputs.
  task automatic step(input logic iv, input logic [31:0] id, input logic ordy,
                      input logic fl, input logic clr);
    logic r0m, x1, x0, ox1, ox0;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
    #1;
    r0m = ordy || (q0.size() == 0);
    chk("in_ready_s1", 32'(rdy1), 32'(ready1m));
    chk("in_ready_s0", 32'(rdy0), 32'(r0m));
    x1  = iv && ready1m;
    x0  = iv && r0m;
    ox1 = (q1.size() != 0) && ordy;
    ox0 = (q0.size() != 0) && ordy;
    @(posedge CLK);
    if (clr) cnt1 = 0;
    else if ((q1.size() != 0) && !ordy && !fl && cnt1 < 7) cnt1++;
    if (clr) cnt0 = 0;
    else if ((q0.size() != 0) && !ordy && !fl && cnt0 < 65535) cnt0++;
    if (fl) begin
      q1.delete();
      q0.delete();
      last1 = '0;
      last0 = '0;
    end else begin
      if (ox1) void'(q1.pop_front());
      if (x1)  q1.push_back(id);
      if (q1.size() != 0) last1 = q1[0];
      if (ox0) void'(q0.pop_front());
      if (x0)  q0.push_back(id);
      if (q0.size() != 0) last0 = q0[0];
    end
    ready1m = fl ? 1'b1 : (q1.size() < 2);
    #1;
    check_outputs();
  endtask

  initial begin
    nRST      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    cnt_clr   = 1'b0;
    model_reset();
    #12;
    check_outputs();
    chk("reset_in_ready_s1", 32'(rdy1), 32'd1);
    chk("reset_in_ready_s0", 32'(rdy0), 32'd1);
    @(posedge CLK);
    #3 nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Streaming 0x1..0x8 at full rate.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
      chk("stream_data", od1, 32'(i));
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Backpressure: 0xA held, 0xB into skid, 0xC refused until space frees.
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'hA, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    chk("bp_occupancy", 32'(occ1), 32'd2);
    chk("bp_hold_data", od1, 32'hA);
    chk("bp_in_ready",  32'(rdy1), 32'd0);
    chk("bp_stall_cnt", 32'(sc1), 32'd3);
    step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    chk("bp_drain_b", od1, 32'hB);
    step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    chk("bp_drain_c", od1, 32'hC);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush in FULL with concurrent input 0xD and out_ready.
    step(1'b1, 32'hA, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hD, 1'b1, 1'b1, 1'b0);
    chk("flush_valid", 32'(ov1), 32'd0);
    chk("flush_ready", 32'(rdy1), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Single-register stage: blocked while full, simultaneous replace when draining.
    step(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h6, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h7, 1'b1, 1'b0, 1'b0);
    chk("s0_replace_occ",  32'(occ0), 32'd1);
    chk("s0_replace_data", od0, 32'h7);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
           ($urandom % 25) == 0, ($urandom % 30) == 0);
    end

    // Asynchronous reset with two entries held.
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_occ", 32'(occ1), 32'd2);
    in_valid = 1'b0;
    #2 nRST = 1'b0;
    #1;
    model_reset();
    chk("async_rst_valid", 32'(ov1), 32'd0);
    chk("async_rst_data",  od1, 32'd0);
    chk("async_rst_occ",   32'(occ1), 32'd0);
    chk("async_rst_cnt",   32'(sc1), 32'd0);
    chk("async_rst_ready", 32'(rdy1), 32'd1);
    #3 nRST = 1'b1;
    @(posedge CLK);
    #1;
    step(1'b1, 32'h44, 1'b1, 1'b0, 1'b0);
    chk("post_reset_accept", od1, 32'h44);

    // Stall counter saturation and clear-with-stall.
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("sat_cnt_max", 32'(sc1), 32'd7);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("sat_cnt_clr", 32'(sc1), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
